// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory read at a time from the
// current PC and queues returned words with their PC toward decode. A control-flow
// flush empties the queue and discards any response still in flight.
module instr_fetch #(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  // program counter stage
  input  logic [31:0] pc_addr,
  output logic        pc_stall,
  input  logic        flush,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decode
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        dec_misaligned
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  typedef logic [AW+1:0] occ_t;

  // StWait: one request outstanding whose data is wanted.
  // StDrop: one request outstanding whose data must be thrown away.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q;

  logic [31:0] fifo_instr_q [DEPTH];
  logic [31:0] fifo_pc_q    [DEPTH];
  logic        fifo_mis_q   [DEPTH];
  ptr_t        wptr_q, rptr_q;
  cnt_t        count_q;

  logic        aligned;
  logic        pop;
  logic        resp_push;
  logic        mis_push;
  logic        push;
  logic        space;
  logic        issue;
  logic        accept;
  occ_t        occ;
  logic [31:0] push_instr;
  logic [31:0] push_pc;
  logic        push_mis;

  assign aligned = (pc_addr[1:0] == 2'b00);
  assign pop     = dec_valid & dec_ready;

  // Response capture, free-space evaluation and request issue decisions.
  always_comb begin
    resp_push = 1'b0;
    mis_push  = 1'b0;
    issue     = 1'b0;
    // Occupancy after this cycle; a response landing now already holds its slot.
    occ   = occ_t'(count_q) + occ_t'(resp_push) - occ_t'(pop);
    space = 1'b0;
    if (!rst) begin
      resp_push = (state_q == StWait) && imem_rvalid && !flush;
      occ       = occ_t'(count_q) + occ_t'(resp_push) - occ_t'(pop);
      space     = (occ < occ_t'(DEPTH));
      if (!flush && space) begin
        if (aligned) begin
          issue = (state_q == StIdle) || ((state_q == StWait) && imem_rvalid);
        end else begin
          // A misaligned PC never reaches memory; it becomes a flagged NOP.
          mis_push = (state_q == StIdle);
        end
      end
    end
  end

  assign accept    = issue & imem_ready;
  assign push      = resp_push | mis_push;
  assign imem_req  = issue;
  assign imem_addr = pc_addr;
  assign pc_stall  = !(accept | mis_push);

  // Select the entry written into the queue this cycle.
  always_comb begin
    push_instr = imem_rdata;
    push_pc    = pend_pc_q;
    push_mis   = 1'b0;
    if (mis_push) begin
      push_instr = NOP;
      push_pc    = pc_addr;
      push_mis   = 1'b1;
    end
  end

  // Fetch FSM next-state logic; flush outranks everything except reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!flush && accept) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (flush) begin
          state_d = imem_rvalid ? StIdle : StDrop;
        end else if (imem_rvalid) begin
          state_d = accept ? StWait : StIdle;
        end
      end
      StDrop: begin
        // The discarded response retires the outstanding request.
        if (imem_rvalid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and the PC of the request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pend_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend_pc_q <= pc_addr;
      end
    end
  end

  // Queue pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + ptr_t'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + ptr_t'(1);
      end
      count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  // Queue storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      fifo_instr_q[wptr_q] <= push_instr;
      fifo_pc_q[wptr_q]    <= push_pc;
      fifo_mis_q[wptr_q]   <= push_mis;
    end
  end

  assign dec_valid      = (count_q != '0);
  assign dec_instr      = dec_valid ? fifo_instr_q[rptr_q] : NOP;
  assign dec_pc         = dec_valid ? fifo_pc_q[rptr_q] : 32'h0;
  assign dec_misaligned = dec_valid & fifo_mis_q[rptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a memory model with variable latency, a PC
// source that follows pc_stall and flush targets, and a queue-based reference of
// what decode should see each cycle.
module tb_instr_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_misaligned;

  instr_fetch #(
    .DEPTH(DEPTH),
    .NOP  (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_addr       (pc_addr),
    .pc_stall      (pc_stall),
    .flush         (flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_misaligned(dec_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // reference: words decode should see, and the fetch in flight
  ent_t        mq[$];
  bit          m_out;
  bit          m_drop;
  logic [31:0] m_pend;

  // environment state
  logic [31:0] pc;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  bit          rst_req;
  bit          force_flush;
  logic [31:0] force_tgt;

  // stimulus knobs (percent, flush in per mille)
  int p_ready, p_dready, p_flush, p_mis, lat_min, lat_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5eed_c0de;
  endfunction

  // One clock cycle: drive inputs, compare against the reference, advance both.
  task automatic step();
    bit          mv, e_valid, e_req, e_stall, pop, resp, space, mis, acc, al;
    int          occ;
    logic [31:0] tgt;
    ent_t        e;
    @(negedge clk);
    mv = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      mv = (mem_cnt == 0);
    end
    imem_rvalid = mv;
    imem_rdata  = mv ? mem_word(mem_addr) : $urandom();
    imem_ready  = (!mem_busy || mv) && ($urandom_range(99) < p_ready);
    dec_ready   = ($urandom_range(99) < p_dready);
    rst         = rst_req;
    flush       = !rst_req && (force_flush || ($urandom_range(999) < p_flush));
    pc_addr     = pc;
    #1;

    e_valid = (mq.size() > 0);
    check("dec_valid", {31'b0, dec_valid}, {31'b0, e_valid});
    check("dec_pc", dec_pc, e_valid ? mq[0].pc : 32'h0);
    check("dec_instr", dec_instr, e_valid ? mq[0].instr : NOP);
    check("dec_mis", {31'b0, dec_misaligned}, {31'b0, e_valid && mq[0].mis});

    al = (pc[1:0] == 2'b00);
    if (rst) begin
      e_req = 0; e_stall = 1; acc = 0; mis = 0; resp = 0; pop = 0;
    end else begin
      pop   = e_valid && dec_ready;
      resp  = m_out && !m_drop && mv && !flush;
      occ   = mq.size() + int'(resp) - int'(pop);
      space = (occ < int'(DEPTH));
      e_req = !flush && space && al && (!m_out || (!m_drop && mv));
      mis   = !flush && space && !al && !m_out;
      acc   = e_req && imem_ready;
      e_stall = !(acc || mis);
    end
    check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    check("pc_stall", {31'b0, pc_stall}, {31'b0, e_stall});
    if (e_req) check("imem_addr", imem_addr, pc);

    // reference update
    if (rst) begin
      mq.delete();
      m_out  = 0;
      m_drop = 0;
    end else if (flush) begin
      mq.delete();
      if (m_out) begin
        if (mv) m_out = 0;
        else    m_drop = 1;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (resp) begin
        e = '{pc: m_pend, instr: imem_rdata, mis: 1'b0};
        mq.push_back(e);
      end
      if (mis) begin
        e = '{pc: pc, instr: NOP, mis: 1'b1};
        mq.push_back(e);
      end
      if (m_out && mv) begin
        m_out  = 0;
        m_drop = 0;
      end
      if (acc) begin
        m_out  = 1;
        m_drop = 0;
        m_pend = pc;
      end
    end

    // environment update (memory and PC source react to the DUT handshake)
    if (mv) mem_busy = 0;
    if (imem_req && imem_ready) begin
      mem_busy = 1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
    end
    if (force_flush) tgt = force_tgt;
    else begin
      tgt = {$urandom_range(32'hffff), 2'b00};
      if ($urandom_range(99) < p_mis) tgt = tgt + 32'd2;
    end
    if (rst)             pc = 32'h0;
    else if (flush)      pc = tgt;
    else if (!pc_stall)  pc = pc + 32'd4;
  endtask

  task automatic flush_to(input logic [31:0] tgt);
    force_flush = 1;
    force_tgt   = tgt;
    step();
    force_flush = 0;
  endtask

  initial begin
    rst = 1; flush = 0; pc_addr = 0; imem_ready = 0; imem_rvalid = 0;
    imem_rdata = 0; dec_ready = 0;
    pc = 0; mem_busy = 0; mem_cnt = 0; mem_addr = 0;
    m_out = 0; m_drop = 0; m_pend = 0;
    force_flush = 0; force_tgt = 0;
    p_ready = 100; p_dready = 100; p_flush = 0; p_mis = 0; lat_min = 1; lat_max = 1;
    rst_req = 1;
    repeat (2) @(posedge clk);

    // streaming with single-cycle memory
    repeat (2) step();
    rst_req = 0;
    repeat (12) step();

    // decode back-pressure fills the queue, then drains
    p_dready = 0;
    repeat (6) step();
    p_dready = 100;
    repeat (10) step();

    // flush while a slow fetch is outstanding: response dropped
    lat_min = 3; lat_max = 3;
    flush_to(32'h8);
    step();
    flush_to(32'h100);
    repeat (10) step();

    // flush coinciding with the response
    lat_min = 1; lat_max = 1;
    flush_to(32'h40);
    step();
    flush_to(32'h80);
    repeat (6) step();

    // misaligned target becomes a flagged NOP
    flush_to(32'h102);
    p_dready = 0;
    repeat (3) step();
    p_dready = 100;
    repeat (3) step();
    flush_to(32'h0);
    repeat (4) step();

    // reset while waiting; the late response must be ignored
    lat_min = 3; lat_max = 3;
    flush_to(32'h200);
    step();
    step();
    rst_req = 1;
    step();
    rst_req = 0;
    repeat (10) step();

    // random traffic
    p_ready = 70; p_dready = 60; p_flush = 50; p_mis = 10; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      rst_req = ($urandom_range(499) == 0);
      step();
    end
    rst_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
